seq_restoring_divider: RTL

//  Sequential unsigned restoring divider: the inverse of the 2x2-bit multiplier datapath.

---
 rtl/div_if.sv | 28 ++
 rtl/seq_restoring_divider.sv | 117 +++++++++++
 2 files changed

// File: rtl/div_if.sv
// Start/busy/done handshake bundle for the sequential restoring divider.
// Master issues jobs; slave (the divider) returns registered results.
interface div_if #(
  parameter int DW = 4,
  parameter int VW = 2
);
  logic          start;
  logic [DW-1:0] dividend;
  logic [VW-1:0] divisor;
  logic          busy;
  logic          done;
  logic [DW-1:0] quotient;
  logic [VW-1:0] remainder;
  logic          div_by_zero;
  logic          chk_err;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder,
    input  div_by_zero, chk_err
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder,
    output div_by_zero, chk_err
  );
endinterface

// File: rtl/seq_restoring_divider.sv
// Unsigned restoring divider, one quotient bit per clock, MSB first.
// Optional DIV_SELFCHECK_EN adds a q*d+r==dividend round-trip check.
module seq_restoring_divider #(
  parameter int DW = 4,
  parameter int VW = 2
) (
  input logic clk,
  input logic rst_n,
  div_if.slave bus
);
  localparam int CW = (DW > 1) ? $clog2(DW) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state, state_n;

  logic [CW-1:0] cnt, idx;
  logic [DW-1:0] dvd, q_sh, q_fin, quo;
  logic [VW-1:0] dvs, rem;
  logic [VW:0]   r, rs, r_n;
  logic          q_bit, accept, last, dz, zdiv;

  always_comb begin
    accept = bus.start && (state != RUN);
    zdiv   = (bus.divisor == '0);
    idx    = CW'(DW - 1) - cnt;
    rs     = {r[VW-1:0], dvd[idx]};
    q_bit  = (rs >= {1'b0, dvs});
    r_n    = q_bit ? rs - {1'b0, dvs} : rs;
    q_fin  = {q_sh[DW-2:0], q_bit};
    last   = (cnt == CW'(DW - 1));
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: begin
        if (bus.start) state_n = zdiv ? DONE : RUN;
      end
      RUN: begin
        if (last) state_n = DONE;
      end
      DONE: begin
        if (bus.start) state_n = zdiv ? DONE : RUN;
        else           state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

`ifdef DIV_SELFCHECK_EN
  logic [DW+VW-1:0] prod;
  logic             chk, chk_n;

  always_comb begin
    prod  = (DW+VW)'(q_fin) * (DW+VW)'(dvs)
          + (DW+VW)'(r_n[VW-1:0]);
    chk_n = (prod != (DW+VW)'(dvd));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                     chk <= 1'b0;
    else if (accept)                chk <= 1'b0;
    else if (state == RUN && last)  chk <= chk_n;
  end

  assign bus.chk_err = chk;
`else
  assign bus.chk_err = 1'b0;
`endif

  // Results land in quo/rem only at DONE entry so they stay stable while held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dvd  <= '0;
      dvs  <= '0;
      r    <= '0;
      cnt  <= '0;
      q_sh <= '0;
      quo  <= '0;
      rem  <= '0;
      dz   <= 1'b0;
    end else if (accept) begin
      dvd  <= bus.dividend;
      dvs  <= bus.divisor;
      r    <= '0;
      cnt  <= '0;
      q_sh <= '0;
      quo  <= zdiv ? '1 : '0;
      rem  <= '0;
      dz   <= zdiv;
    end else if (state == RUN) begin
      r    <= r_n;
      q_sh <= q_fin;
      cnt  <= cnt + CW'(1);
      if (last) begin
        quo <= q_fin;
        rem <= r_n[VW-1:0];
      end
    end
  end

  assign bus.busy        = (state == RUN);
  assign bus.done        = (state == DONE);
  assign bus.quotient    = quo;
  assign bus.remainder   = rem;
  assign bus.div_by_zero = dz;
endmodule
